// File: rtl/mux_layer3_rr.sv
// mux_layer3_rr: merges four 4-bit lanes, each buffered in its own FIFO, into
// one registered stream using a round-robin arbiter (at most one word/clock).
// Optional feature macro: DROP_CNT_EN adds the saturating drop_cnt output.
module mux_layer3_rr #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in00,
  input  logic [DATA_W-1:0] data_in01,
  input  logic [DATA_W-1:0] data_in10,
  input  logic [DATA_W-1:0] data_in11,
  input  logic [3:0]        valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_out,
  output logic [3:0]        fifo_full,
`ifdef DROP_CNT_EN
  output logic [3:0]        fifo_empty,
  output logic [7:0]        drop_cnt
`else
  output logic [3:0]        fifo_empty
`endif
);

  logic [DATA_W-1:0] lane_data_s [4];
  logic [DATA_W-1:0] mem_q       [4][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q    [4];
  logic [PTR_W-1:0]  rd_ptr_q    [4];
  logic [PTR_W:0]    count_q     [4];
  logic [PTR_W:0]    count_d     [4];
  logic [3:0]        push_s;
  logic [3:0]        drop_s;
  logic [3:0]        pop_s;
  logic              found_s;
  logic [1:0]        sel_s;
  logic [1:0]        rr_ptr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              valid_out_q;
  logic [1:0]        lane_out_q;

  assign lane_data_s[0] = data_in00;
  assign lane_data_s[1] = data_in01;
  assign lane_data_s[2] = data_in10;
  assign lane_data_s[3] = data_in11;

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign lane_out  = lane_out_q;

  // Decode full/empty flags from the registered counts; a full lane drops its input.
  always_comb begin
    fifo_full  = 4'h0;
    fifo_empty = 4'h0;
    push_s     = 4'h0;
    drop_s     = 4'h0;
    for (int i = 0; i < 4; i++) begin
      fifo_full[i]  = (count_q[i] == (PTR_W+1)'(FIFO_DEPTH));
      fifo_empty[i] = (count_q[i] == (PTR_W+1)'(0));
      push_s[i]     = valid_in[i] & ~fifo_full[i];
      drop_s[i]     = valid_in[i] &  fifo_full[i];
    end
  end

  // Round-robin search starting at rr_ptr for the first non-empty lane.
  always_comb begin
    found_s = 1'b0;
    sel_s   = rr_ptr_q;
    pop_s   = 4'h0;
    for (int k = 0; k < 4; k++) begin
      if (!found_s && !fifo_empty[rr_ptr_q + k[1:0]]) begin
        found_s = 1'b1;
        sel_s   = rr_ptr_q + k[1:0];
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      pop_s[sel_s] = 1'b1;
    end else begin
      pop_s = 4'h0;
    end
  end

  // Next occupancy per lane: count += push - pop.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      count_d[i] = count_q[i];
      case ({push_s[i], pop_s[i]})
        2'b10:   count_d[i] = count_q[i] + (PTR_W+1)'(1);
        2'b01:   count_d[i] = count_q[i] - (PTR_W+1)'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // FIFO pointers and counts; reset overrides any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        wr_ptr_q[i] <= {PTR_W{1'b0}};
        rd_ptr_q[i] <= {PTR_W{1'b0}};
        count_q[i]  <= {(PTR_W+1){1'b0}};
      end else begin
        if (push_s[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop_s[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        count_q[i] <= count_d[i];
      end
    end
  end

  // FIFO storage; contents survive reset since the pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset && push_s[i]) begin
        mem_q[i][wr_ptr_q[i]] <= lane_data_s[i];
      end
    end
  end

  // Registered output stage and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= {DATA_W{1'b0}};
      valid_out_q <= 1'b0;
      lane_out_q  <= 2'd0;
      rr_ptr_q    <= 2'd0;
    end else if (found_s) begin
      data_out_q  <= mem_q[sel_s][rd_ptr_q[sel_s]];
      valid_out_q <= 1'b1;
      lane_out_q  <= sel_s;
      rr_ptr_q    <= sel_s + 2'd1;
    end else begin
      data_out_q  <= {DATA_W{1'b0}};
      valid_out_q <= 1'b0;
    end
  end

`ifdef DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic [2:0] drop_num_s;
  logic [8:0] drop_sum_s;

  // Number of lanes dropping this cycle and the saturating running total.
  always_comb begin
    drop_num_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      drop_num_s = drop_num_s + {2'b00, drop_s[i]};
    end
    drop_sum_s = {1'b0, drop_cnt_q} + {6'd0, drop_num_s};
  end

  // Drop counter, saturating at 8'hFF and cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else if (drop_sum_s > 9'h0FF) begin
      drop_cnt_q <= 8'hFF;
    end else begin
      drop_cnt_q <= drop_sum_s[7:0];
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop_s;
  assign unused_drop_s = ^drop_s;
`endif

endmodule

// File: tb/tb_mux_layer3_rr.sv
// Randomized and directed bench for mux_layer3_rr with a queue-based lane
// model feeding a scoreboard; a negedge monitor compares DUT outputs.
module tb_mux_layer3_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din [4];
  logic [3:0] valid_in;
  logic [3:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic [3:0] fifo_full;
  logic [3:0] fifo_empty;
`ifdef DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  mux_layer3_rr dut (
    .clk(clk), .reset(reset),
    .data_in00(din[0]), .data_in01(din[1]), .data_in10(din[2]), .data_in11(din[3]),
    .valid_in(valid_in), .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
    .fifo_full(fifo_full),
`ifdef DROP_CNT_EN
    .fifo_empty(fifo_empty), .drop_cnt(drop_cnt)
`else
    .fifo_empty(fifo_empty)
`endif
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [3:0] mq [4][$];
  int         rr = 0;
  bit         ev = 1'b0;
  logic [1:0] el = 2'd0;
  int         mdrops = 0;
  logic [5:0] sb [$];      // expected {lane, data}, pushed at pop time
  logic [5:0] olog [$];    // observed {lane, data}
  int         pulses = 0;
  bit         mon_en = 1'b0;
  bit         saw_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the lane model by one clock edge using the inputs now being driven.
  task automatic model_step();
    bit pf [4];
    logic [3:0] w;
    if (reset) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      rr = 0; ev = 1'b0; el = 2'd0; mdrops = 0;
      sb.delete();
      mon_en = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) pf[i] = (mq[i].size() == 4);
      ev = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int l;
        l = (rr + k) % 4;
        if (!ev && mq[l].size() > 0) begin
          ev = 1'b1;
          w  = mq[l].pop_front();
          el = 2'(l);
          sb.push_back({el, w});
        end
      end
      if (ev) rr = (el + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (valid_in[i]) begin
          if (pf[i]) mdrops = (mdrops < 255) ? mdrops + 1 : 255;
          else       mq[i].push_back(din[i]);
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input logic [3:0] v, input logic [3:0] d0,
                     input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
    @(negedge clk);
    #1;
    reset = r; valid_in = v;
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
    model_step();
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // Monitor: compare DUT outputs against the model after every edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] me, mf;
      logic [5:0] e;
      for (int i = 0; i < 4; i++) begin
        me[i] = (mq[i].size() == 0);
        mf[i] = (mq[i].size() == 4);
      end
      chk("valid_out", 32'(valid_out), 32'(ev));
      chk("lane_out", 32'(lane_out), 32'(el));
      if (valid_out === 1'b1) begin
        pulses++;
        olog.push_back({lane_out, data_out});
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e[3:0]));
          chk("lane_sb", 32'(lane_out), 32'(e[5:4]));
        end
      end else begin
        chk("data_out_idle", 32'(data_out), 32'd0);
      end
      chk("fifo_empty", 32'(fifo_empty), 32'(me));
      chk("fifo_full", 32'(fifo_full), 32'(mf));
      if (|fifo_full) saw_full = 1'b1;
`ifdef DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(mdrops));
`endif
    end
  end

  task automatic chk_log(input string name, input logic [5:0] exp [$]);
    chk({name, "_len"}, 32'(olog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < olog.size(); i++) chk(name, 32'(olog[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [5:0] exp [$];
    reset = 1'b1; valid_in = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = 4'h0;

    // 1: reset with random inputs
    cyc(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    cyc(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    idle(1);

    // 2: single word on lane 00
    olog.delete();
    cyc(1'b0, 4'b0001, 4'hA, 4'h0, 4'h0, 4'h0);
    idle(5);
    exp = '{{2'd0, 4'hA}};
    chk_log("single_word", exp);

    // 3: one word on every lane in one cycle
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    olog.delete();
    cyc(1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4);
    idle(6);
    exp = '{{2'd0, 4'h1}, {2'd1, 4'h2}, {2'd2, 4'h3}, {2'd3, 4'h4}};
    chk_log("all_lanes", exp);

    // 4: lanes 00 and 11 alternate
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    olog.delete();
    cyc(1'b0, 4'b1001, 4'h5, 4'h0, 4'h0, 4'h8);
    cyc(1'b0, 4'b1001, 4'h6, 4'h0, 4'h0, 4'h9);
    cyc(1'b0, 4'b1001, 4'h7, 4'h0, 4'h0, 4'hA);
    idle(8);
    exp = '{{2'd0, 4'h5}, {2'd3, 4'h8}, {2'd0, 4'h6}, {2'd3, 4'h9}, {2'd0, 4'h7}, {2'd3, 4'hA}};
    chk_log("alternate", exp);

    // 5: overload all lanes for 8 cycles
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    pulses = 0; saw_full = 1'b0;
    for (int c = 0; c < 8; c++)
      cyc(1'b0, 4'hF, 4'(c*4), 4'(c*4+1), 4'(c*4+2), 4'(c*4+3));
    idle(20);
    chk("pulses_plus_drops", 32'(pulses + mdrops), 32'd32);
    chk("saw_full", 32'(saw_full), 32'd1);

    // 6: reset with words buffered everywhere
    for (int c = 0; c < 3; c++) cyc(1'b0, 4'hF, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    pulses = 0;
    idle(8);
    chk("no_pulse_after_reset", 32'(pulses), 32'd0);

    // random traffic with occasional reset
    for (int c = 0; c < 500; c++) begin
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 99) < ((c < 250) ? 25 : 60));
      cyc(($urandom_range(0, 99) < 2), v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    idle(24);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
